// File: rtl/pipelined_adder_n.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-wide slice per stage.
// Valid/ready handshake with global stall; carry ripples stage to stage.
module pipelined_adder_n #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  // a: finished sum bits below the current slice, raw x bits above it
  // b: effective second operand (already inverted for sub)
  // c: carry into the next slice
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
  } stg_t;

  stg_t cur   [STAGES];
  stg_t nxt   [STAGES];
  stg_t q     [STAGES];
  logic vld_q [STAGES];
  logic ovf_q;
  logic ovf_n;
  logic en;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK:0] sum;
    stg_t           n_l;

    if (k == 0) begin : g_head
      assign cur[k] = '{
        a: x,
        b: (sub ? ~y : y),
        c: (sub | cin)
      };
    end else begin : g_body
      assign cur[k] = q[k-1];
    end

    assign sum = {1'b0, cur[k].a[k*CHUNK +: CHUNK]}
               + {1'b0, cur[k].b[k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, cur[k].c};

    // Splice this stage's slice into the running result
    always_comb begin
      n_l = cur[k];
      n_l.a[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      n_l.c = sum[CHUNK];
    end

    assign nxt[k] = n_l;
  end

  // Carry into the MSB is x^y'^s at that bit; xor with carry out
  assign ovf_n = cur[STAGES-1].a[WIDTH-1]
               ^ cur[STAGES-1].b[WIDTH-1]
               ^ nxt[STAGES-1].a[WIDTH-1]
               ^ nxt[STAGES-1].c;

  // All stages advance together when the output is free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        q[k]     <= '0;
        vld_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        q[k] <= nxt[k];
      end
      ovf_q <= ovf_n;
    end
  end

  logic unused_b;
  assign unused_b = ^q[STAGES-1].b;

  assign s         = q[STAGES-1].a;
  assign cout      = q[STAGES-1].c;
  assign ovf       = ovf_q;
  assign out_valid = vld_q[STAGES-1];

endmodule
